// File: rtl/mxint_stream_arbiter.sv
// Round-robin arbiter that shares one MXINT block channel (IN_NUM mantissas
// plus one shared exponent) among NUM_REQ producers. A grant lasts one burst,
// which ends on data_in_last or after MAX_BURST beats. Beats pass through a
// one-entry output register, so one beat per cycle can flow while locked.
module mxint_stream_arbiter #(
  parameter int DATA_PRECISION_0 = 8,
  parameter int DATA_PRECISION_1 = 8,
  parameter int IN_NUM           = 4,
  parameter int NUM_REQ          = 4,
  parameter int MAX_BURST        = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NUM_REQ-1:0][IN_NUM-1:0][DATA_PRECISION_0-1:0]  mdata_in,
  input  logic [NUM_REQ-1:0][DATA_PRECISION_1-1:0]              edata_in,
  input  logic [NUM_REQ-1:0]                                    data_in_last,
  input  logic [NUM_REQ-1:0]                                    data_in_valid,
  output logic [NUM_REQ-1:0]                                    data_in_ready,
  output logic [IN_NUM-1:0][DATA_PRECISION_0-1:0]               mdata_out,
  output logic [DATA_PRECISION_1-1:0]                           edata_out,
  output logic                                                  data_out_last,
  output logic                                                  data_out_valid,
  input  logic                                                  data_out_ready,
  output logic [$clog2(NUM_REQ)-1:0]                            grant_id,
  output logic                                                  grant_active
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [ID_W-1:0]  RR_RST   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e                                 state_q, state_d;
  logic [ID_W-1:0]                        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                        grant_id_q, grant_id_d;
  logic [CNT_W-1:0]                       beat_cnt_q, beat_cnt_d;
  logic [IN_NUM-1:0][DATA_PRECISION_0-1:0] mdata_q, mdata_d;
  logic [DATA_PRECISION_1-1:0]            edata_q, edata_d;
  logic                                   last_q, last_d;
  logic                                   valid_q, valid_d;

  logic                                   pick_found_s;
  logic [ID_W-1:0]                        pick_id_s;
  logic [ID_W-1:0]                        scan_id_s;
  logic                                   out_ready_int_s;
  logic                                   accept_s;
  logic                                   burst_end_s;
  logic [NUM_REQ-1:0]                     ready_s;

  // Round-robin search: first valid requester after the previous owner.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    scan_id_s    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_id_s = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found_s && data_in_valid[scan_id_s]) begin
        pick_found_s = 1'b1;
        pick_id_s    = scan_id_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Handshake terms: the output register can take a beat when empty or draining.
  always_comb begin
    out_ready_int_s = !valid_q || data_out_ready;
    accept_s        = (state_q == S_LOCKED) && data_in_valid[grant_id_q] && out_ready_int_s;
    burst_end_s     = data_in_last[grant_id_q] || (beat_cnt_q == LAST_CNT);
    ready_s         = '0;
    if (state_q == S_LOCKED) begin
      ready_s[grant_id_q] = out_ready_int_s;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state logic for the grant FSM, pointer and beat counter.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found_s) begin
          grant_id_d = pick_id_s;
          state_d    = S_LOCKED;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (accept_s && burst_end_s) begin
          state_d    = S_IDLE;
          rr_ptr_d   = grant_id_q;
          beat_cnt_d = '0;
        end else if (accept_s) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Output register: load on accept, otherwise drain when downstream takes it.
  always_comb begin
    mdata_d = mdata_q;
    edata_d = edata_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (accept_s) begin
      mdata_d = mdata_in[grant_id_q];
      edata_d = edata_in[grant_id_q];
      last_d  = burst_end_s;
      valid_d = 1'b1;
    end else if (data_out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and datapath registers; reset discards any in-flight beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= RR_RST;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      mdata_q    <= '0;
      edata_q    <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      mdata_q    <= mdata_d;
      edata_q    <= edata_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign data_in_ready  = ready_s;
  assign mdata_out      = mdata_q;
  assign edata_out      = edata_q;
  assign data_out_last  = last_q;
  assign data_out_valid = valid_q;
  assign grant_id       = grant_id_q;
  assign grant_active   = (state_q == S_LOCKED);

endmodule

// File: tb/tb_mxint_stream_arbiter.sv
// Scoreboard bench for mxint_stream_arbiter: sources stream from per-requester
// queues, a queue-level reference model predicts the arbitrated output stream,
// and an independent monitor compares every beat the DUT hands downstream.
module tb_mxint_stream_arbiter;

  localparam int P0 = 8;
  localparam int P1 = 8;
  localparam int IN = 4;
  localparam int NR = 4;
  localparam int MB = 16;

  typedef struct packed {
    logic [IN-1:0][P0-1:0] m;
    logic [P1-1:0]         e;
    logic                  l;
  } beat_t;

  logic                        clk;
  logic                        rst;
  logic [NR-1:0][IN-1:0][P0-1:0] mdata_in;
  logic [NR-1:0][P1-1:0]       edata_in;
  logic [NR-1:0]               vin_last;
  logic [NR-1:0]               vin;
  logic [NR-1:0]               rdy;
  logic [IN-1:0][P0-1:0]       mout;
  logic [P1-1:0]               eout;
  logic                        lout;
  logic                        dov;
  logic                        dor;
  logic [1:0]                  gid;
  logic                        ga;

  mxint_stream_arbiter #(
    .DATA_PRECISION_0(P0), .DATA_PRECISION_1(P1), .IN_NUM(IN),
    .NUM_REQ(NR), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .mdata_in(mdata_in), .edata_in(edata_in),
    .data_in_last(vin_last), .data_in_valid(vin), .data_in_ready(rdy),
    .mdata_out(mout), .edata_out(eout), .data_out_last(lout),
    .data_out_valid(dov), .data_out_ready(dor),
    .grant_id(gid), .grant_active(ga)
  );

  beat_t src_q [NR][$];
  beat_t stage [NR][$];
  beat_t exp_q [$];
  int    chk = 0;
  int    fail = 0;
  int    m_rr = NR - 1;
  int    fire_total = 0;
  int    run_len = 0;
  int    last_run = 0;
  int    bp_mode = 0;
  bit    force_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(input int r, input int seq, input bit last);
    beat_t b;
    logic [7:0] tag;
    for (int k = 0; k < IN; k++) b.m[k] = P0'($urandom);
    tag    = {r[1:0], seq[5:0]};
    b.m[0] = tag;
    b.e    = P1'($urandom);
    b.l    = last;
    return b;
  endfunction

  // Queue-level model: next non-empty source after the last owner gets a
  // burst of up to MB beats that stops at its last flag.
  task automatic launch();
    beat_t mq [NR][$];
    beat_t b;
    beat_t e;
    int    found;
    int    cnt;
    for (int r = 0; r < NR; r++) mq[r] = stage[r];
    while (1) begin
      found = -1;
      for (int k = 1; k <= NR; k++)
        if (found < 0 && mq[(m_rr + k) % NR].size() > 0) found = (m_rr + k) % NR;
      if (found < 0) break;
      cnt = 0;
      do begin
        b   = mq[found].pop_front();
        cnt = cnt + 1;
        e   = b;
        e.l = b.l || (cnt == MB);
        exp_q.push_back(e);
      end while (!e.l && mq[found].size() > 0);
      m_rr = found;
    end
    for (int r = 0; r < NR; r++) begin
      foreach (stage[r][j]) src_q[r].push_back(stage[r][j]);
      stage[r].delete();
    end
  endtask

  task automatic add_burst(input int r, input int len, input bit with_last);
    for (int s = 0; s < len; s++)
      stage[r].push_back(mk(r, stage[r].size() + src_q[r].size() + s, with_last && (s == len - 1)));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk = chk + 1;
    if (act !== req) begin
      fail = fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < 3000) begin
      @(posedge clk);
      n = n + 1;
      busy = (exp_q.size() != 0);
      for (int r = 0; r < NR; r++) if (src_q[r].size() != 0) busy = 1'b1;
    end
    check("drain_timeout", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  // Source driver: present queue heads, retire the ones accepted last edge.
  initial begin
    bit fired [NR];
    vin = '0; vin_last = '0; mdata_in = '0; edata_in = '0; dor = 1'b1;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) fired[r] = vin[r] && rdy[r];
      @(posedge clk);
      #1;
      if (rst)
        for (int r = 0; r < NR; r++)
          if (fired[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
      for (int r = 0; r < NR; r++) begin
        if (src_q[r].size() > 0) begin
          vin[r]      = 1'b1;
          vin_last[r] = src_q[r][0].l;
          mdata_in[r] = src_q[r][0].m;
          edata_in[r] = src_q[r][0].e;
        end else begin
          vin[r]      = force_valid;
          vin_last[r] = 1'b0;
        end
      end
      if (bp_mode == 1) dor = ($urandom_range(0, 3) != 0);
      else if (bp_mode == 2) dor = !dor;
      else dor = 1'b1;
    end
  end

  // Monitor: compare each downstream transfer against the scoreboard and
  // require a stalled beat to stay put.
  initial begin
    beat_t e;
    bit    stall_prev = 1'b0;
    logic [IN-1:0][P0-1:0] pm;
    logic [P1-1:0] pe;
    logic pl;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
        run_len    = 0;
      end else begin
        if (stall_prev) begin
          chk = chk + 1;
          if (!(dov && mout == pm && eout == pe && lout == pl)) begin
            fail = fail + 1;
            $display("FAIL stall_hold: got v=%0b m=%h e=%h l=%0b expected v=1 m=%h e=%h l=%0b",
                     dov, mout, eout, lout, pm, pe, pl);
          end
        end
        if (dov && dor) begin
          fire_total = fire_total + 1;
          run_len    = run_len + 1;
          chk        = chk + 1;
          if (exp_q.size() == 0) begin
            fail = fail + 1;
            $display("FAIL unexpected_beat: got m=%h e=%h l=%0b expected none", mout, eout, lout);
          end else begin
            e = exp_q.pop_front();
            if (mout !== e.m || eout !== e.e || lout !== e.l) begin
              fail = fail + 1;
              $display("FAIL out_beat: got m=%h e=%h l=%0b expected m=%h e=%h l=%0b",
                       mout, eout, lout, e.m, e.e, e.l);
            end
          end
        end else begin
          if (run_len > 0) last_run = run_len;
          run_len = 0;
        end
        stall_prev = dov && !dor;
        pm = mout; pe = eout; pl = lout;
      end
    end
  end

  // Control: directed scenarios followed by randomized rounds.
  initial begin
    int base;
    int n;
    rst = 1'b0;
    force_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(rdy), 64'd0);
    check("rst_out_valid", 64'(dov), 64'd0);
    check("rst_grant_active", 64'(ga), 64'd0);
    check("rst_grant_id", 64'(gid), 64'd0);
    check("rst_out_data", 64'({mout, eout, lout}), 64'd0);
    force_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fairness: 2 two-beat bursts per requester, order 0,1,2,3,0,1,2,3.
    bp_mode = 0;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      add_burst(r, 2, 1'b1);
      add_burst(r, 2, 1'b1);
    end
    launch();
    wait_drain();

    // Backpressure: toggling downstream ready over a 6-beat burst.
    bp_mode = 2;
    @(negedge clk);
    add_burst(0, 6, 1'b1);
    launch();
    wait_drain();

    // Throughput: 8 back-to-back beats with ready held high.
    bp_mode = 0;
    @(negedge clk);
    add_burst(2, 8, 1'b1);
    launch();
    wait_drain();
    check("throughput_run", 64'(last_run), 64'd8);

    // Forced release: 32 beats without last, another requester in between.
    @(negedge clk);
    add_burst(1, 32, 1'b0);
    add_burst(2, 3, 1'b1);
    launch();
    wait_drain();

    // Randomized rounds with random backpressure.
    bp_mode = 1;
    for (int round = 0; round < 6; round++) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        n = $urandom_range(0, 2);
        for (int b = 0; b < n; b++) add_burst(r, $urandom_range(1, 20), 1'b1);
      end
      launch();
      wait_drain();
    end

    // Async reset on beat 3 of 5, then round robin restarts at requester 0.
    bp_mode = 0;
    @(negedge clk);
    base = fire_total;
    add_burst(2, 5, 1'b1);
    launch();
    n = 0;
    while ((fire_total - base) != 2 && n < 200) begin
      @(posedge clk);
      #2;
      n = n + 1;
    end
    check("midburst_reach", 64'(fire_total - base), 64'd2);
    check("midburst_valid", 64'(dov), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(dov), 64'd0);
    check("async_rst_active", 64'(ga), 64'd0);
    check("async_rst_ready", 64'(rdy), 64'd0);
    check("async_rst_last", 64'(lout), 64'd0);
    for (int r = 0; r < NR; r++) src_q[r].delete();
    exp_q.delete();
    m_rr = NR - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    add_burst(3, 2, 1'b1);
    add_burst(1, 2, 1'b1);
    add_burst(0, 2, 1'b1);
    launch();
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", chk, fail);
    $finish;
  end

endmodule
